// File: rtl/mac_accumulator_c3x3_27bits_if.sv
// Beat-in / result-out bundle for the C3x3 27-bit multiplier accumulation stage.
// master = producer/consumer side (testbench), slave = accumulator side.
interface mac_accumulator_c3x3_27bits_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [1:0]       mode;
  logic             a_sign;
  logic             b_sign;
  logic [53:0]      result_0;
  logic [11:0]      result_simd_carry;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      acc_out;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] out_count;
  logic             err;

  modport master (
    output in_valid, in_first, in_last, mode, a_sign, b_sign,
           result_0, result_simd_carry, out_ready,
    input  in_ready, out_valid, acc_out, out_mode, out_count, err
  );

  modport slave (
    input  in_valid, in_first, in_last, mode, a_sign, b_sign,
           result_0, result_simd_carry, out_ready,
    output in_ready, out_valid, acc_out, out_mode, out_count, err
  );
endinterface

// File: rtl/mac_accumulator_c3x3_27bits.sv
// Per-lane packet accumulator behind the C3x3 27-bit multiplier: register and split
// lanes, accumulate across a packet, hold the final sums on a valid/ready port.
module mac_accumulator_c3x3_27bits #(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mac_accumulator_c3x3_27bits_if.slave  mac_if
);

  localparam logic [1:0]       MODE_27X27 = 2'b00;
  localparam logic [1:0]       MODE_9X9   = 2'b01;
  localparam logic [1:0]       MODE_4X4   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACC} state_e;

  logic stall;

  // Stage 1: lane extraction
  logic [1:0]  in_mode;
  logic        lane_signed;
  logic [19:0] lane20;
  logic [63:0] lanes_d;

  logic        s1_valid_q;
  logic        s1_first_q;
  logic        s1_last_q;
  logic [1:0]  s1_mode_q;
  logic [63:0] s1_lanes_q;

  // Stage 2: accumulation and packet FSM
  state_e           state_q;
  logic [63:0]      acc_q;
  logic [63:0]      sum_d;
  logic [1:0]       pkt_mode_q;
  logic [CNT_W-1:0] count_q;
  logic             done_q;
  logic             err_q;

  // Output register
  logic             out_valid_q;
  logic [63:0]      acc_out_q;
  logic [1:0]       out_mode_q;
  logic [CNT_W-1:0] out_count_q;

  // A held result that is not being taken freezes the whole pipeline.
  assign stall           = out_valid_q & ~mac_if.out_ready;
  assign mac_if.in_ready = ~stall;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned (latch).
    in_mode     = (mac_if.mode == 2'b11) ? MODE_4X4 : mac_if.mode;
    lane_signed = mac_if.a_sign | mac_if.b_sign;
    lane20      = '0;
    lanes_d     = '0;
    case (in_mode)
      MODE_27X27: lanes_d = {{10{lane_signed & mac_if.result_0[53]}}, mac_if.result_0};
      MODE_9X9: begin
        for (int k = 0; k < 3; k++) begin
          lane20 = {mac_if.result_simd_carry[4*k+2 +: 2], mac_if.result_0[18*k +: 18]};
          lanes_d[21*k +: 21] = {lane_signed & lane20[19], lane20};
        end
      end
      default: begin
        for (int j = 0; j < 6; j++) begin
          lanes_d[10*j +: 10] = {mac_if.result_simd_carry[2*j +: 2], mac_if.result_0[9*j +: 8]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every stage samples pre-edge values.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= MODE_27X27;
      s1_lanes_q <= '0;
    end else if (!stall) begin
      s1_valid_q <= mac_if.in_valid;
      if (mac_if.in_valid) begin
        s1_first_q <= mac_if.in_first;
        s1_last_q  <= mac_if.in_last;
        s1_mode_q  <= in_mode;
        s1_lanes_q <= lanes_d;
      end
    end
  end

  // Lane-wise add; each lane wraps at its own width so no carry leaks into a neighbour.
  always_comb begin
    sum_d = '0;
    case (s1_mode_q)
      MODE_27X27: sum_d = acc_q + s1_lanes_q;
      MODE_9X9: begin
        for (int k = 0; k < 3; k++) begin
          sum_d[21*k +: 21] = acc_q[21*k +: 21] + s1_lanes_q[21*k +: 21];
        end
      end
      default: begin
        for (int j = 0; j < 6; j++) begin
          sum_d[10*j +: 10] = acc_q[10*j +: 10] + s1_lanes_q[10*j +: 10];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pkt_mode_q <= MODE_27X27;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (!stall) begin
      done_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        if (state_q == IDLE || s1_first_q) begin
          // Stray beat in IDLE or a re-open while ACC both restart the packet but are flagged.
          acc_q      <= s1_lanes_q;
          pkt_mode_q <= s1_mode_q;
          count_q    <= CNT_ONE;
          if (state_q == ACC || !s1_first_q) err_q <= 1'b1;
        end else if (s1_mode_q != pkt_mode_q) begin
          err_q <= 1'b1;
        end else begin
          acc_q <= sum_d;
          if (count_q != '1) count_q <= count_q + CNT_ONE;
        end
        state_q <= s1_last_q ? IDLE : ACC;
      end
    end
  end

  // The acc stage may restart at the same edge this captures; it reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      out_mode_q  <= MODE_27X27;
      out_count_q <= '0;
    end else if (!stall) begin
      out_valid_q <= done_q;
      if (done_q) begin
        acc_out_q   <= acc_q;
        out_mode_q  <= pkt_mode_q;
        out_count_q <= count_q;
      end
    end
  end

  assign mac_if.out_valid = out_valid_q;
  assign mac_if.acc_out   = acc_out_q;
  assign mac_if.out_mode  = out_mode_q;
  assign mac_if.out_count = out_count_q;
  assign mac_if.err       = err_q;

endmodule

// File: tb/tb_mac_accumulator_c3x3_27bits.sv
// Directed-vector bench for mac_accumulator_c3x3_27bits: expected packets go into a
// queue at issue time and a negedge monitor compares each accepted result.
module tb_mac_accumulator_c3x3_27bits;

  localparam int CNT_W = 16;

  typedef struct {
    logic [63:0]      acc;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  mac_accumulator_c3x3_27bits_if #(.CNT_W(CNT_W)) bus ();

  mac_accumulator_c3x3_27bits #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mac_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] acc, input logic [1:0] mode,
                          input logic [CNT_W-1:0] cnt, input logic err);
    exp_t e;
    e.acc  = acc;
    e.mode = mode;
    e.cnt  = cnt;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic first, input logic last, input logic [1:0] mode,
                           input logic sgn, input logic [53:0] r0, input logic [11:0] carry);
    bit accepted;
    accepted = 1'b0;
    bus.in_valid          = 1'b1;
    bus.in_first          = first;
    bus.in_last           = last;
    bus.mode              = mode;
    bus.a_sign            = sgn;
    bus.b_sign            = 1'b0;
    bus.result_0          = r0;
    bus.result_simd_carry = carry;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0 for 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted result against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: acc_out=%0h appeared, expected no result", bus.acc_out);
        end else begin
          e = exp_q.pop_front();
          check("acc_out",   bus.acc_out,   e.acc);
          check("out_mode",  64'(bus.out_mode),  64'(e.mode));
          check("out_count", 64'(bus.out_count), 64'(e.cnt));
          check("err",       64'(bus.err),       64'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.mode     = 2'b00;
    bus.a_sign   = 1'b0;
    bus.b_sign   = 1'b0;
    bus.result_0 = '0;
    bus.result_simd_carry = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_acc_out",   bus.acc_out,        64'd0);
    check("rst_out_mode",  64'(bus.out_mode),  64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_err",       64'(bus.err),       64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mode 00 signed: -6 + 10 = 4, with two-edge latency
    push_exp(64'd4, 2'b00, 16'd2, 1'b0);
    send_beat(1'b1, 1'b0, 2'b00, 1'b1, 54'h3FFFFFFFFFFFFA, 12'h0);
    send_beat(1'b0, 1'b1, 2'b00, 1'b1, 54'd10, 12'h0);
    @(negedge clk);
    @(negedge clk);
    check("latency_t1_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("latency_t2_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Mode 01 unsigned single-beat packet, lanes 5/7/9
    push_exp((64'd9 << 42) | (64'd7 << 21) | 64'd5, 2'b01, 16'd1, 1'b0);
    send_beat(1'b1, 1'b1, 2'b01, 1'b0, {18'd9, 18'd7, 18'd5}, 12'h0);
    wait_drain();

    // Mode 10 lane-0 wrap: 3FF + 002 = 001, no spill into lane 1
    push_exp(64'h1, 2'b10, 16'd2, 1'b0);
    send_beat(1'b1, 1'b0, 2'b10, 1'b0, 54'hFF, 12'h3);
    send_beat(1'b0, 1'b1, 2'b10, 1'b0, 54'h02, 12'h0);
    wait_drain();

    // Backpressure: result A held, beat B blocked for 5 cycles
    bus.out_ready = 1'b0;
    push_exp(64'd11, 2'b00, 16'd1, 1'b0);
    send_beat(1'b1, 1'b1, 2'b00, 1'b0, 54'd11, 12'h0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
    push_exp(64'd22, 2'b00, 16'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    bus.mode     = 2'b00;
    bus.a_sign   = 1'b0;
    bus.result_0 = 54'd22;
    bus.result_simd_carry = 12'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("bp_acc_out_stable", bus.acc_out, 64'd11);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_beat(1'b1, 1'b1, 2'b00, 1'b0, 54'd22, 12'h0);
    wait_drain();

    // Mode mismatch: middle mode-01 beat dropped, err raised
    push_exp(64'd7, 2'b00, 16'd2, 1'b1);
    send_beat(1'b1, 1'b0, 2'b00, 1'b0, 54'd3, 12'h0);
    send_beat(1'b0, 1'b0, 2'b01, 1'b0, 54'd100, 12'h0);
    send_beat(1'b0, 1'b1, 2'b00, 1'b0, 54'd4, 12'h0);
    wait_drain();
    check("mismatch_err_sticky", 64'(bus.err), 64'd1);

    // Reset mid-packet, then fresh single-beat packet of 7
    send_beat(1'b1, 1'b0, 2'b00, 1'b0, 54'd1, 12'h0);
    send_beat(1'b0, 1'b0, 2'b00, 1'b0, 54'd1, 12'h0);
    send_beat(1'b0, 1'b0, 2'b00, 1'b0, 54'd1, 12'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_err",       64'(bus.err),       64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_no_output", 64'(bus.out_valid), 64'd0);
    push_exp(64'd7, 2'b00, 16'd1, 1'b0);
    send_beat(1'b1, 1'b1, 2'b00, 1'b0, 54'd7, 12'h0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator_c3x3_27bits.md
# mac_accumulator_c3x3_27bits

Downstream accumulation stage for the C3x3 27-bit multiplier. It registers the multiplier's combinational outputs (result_0, result_SIMD_carry) together with framing, and extracts one, three or six lanes according to mode. It accumulates each lane across a packet of beats and presents the final per-lane sums on a valid/ready output port with a beat count.

## Interface
- CNT_W, 16, width of beat counter (out_count); saturates at 2^CNT_W-1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_first  in  1  beat opens a packet (accumulators load instead of add)
- in_last  in  1  beat closes a packet (sums go to output)
- mode  in  2  00 = 27x27, 01 = sum_9x9, 10 = sum_4x4, 11 = reserved (treated as 10)
- a_sign, b_sign  in  1  operand signedness; lane data signed iff a_sign|b_sign
- result_0  in  54  multiplier result_0
- result_SIMD_carry  in  12  multiplier SIMD carry bits
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts when out_valid & out_ready
- acc_out  out  64  packed lane sums
- out_mode  out  2  packet mode
- out_count  out  CNT_W  accepted beats in packet (saturating)
- err  out  1  sticky framing/mode error

## Operation
- Lane extraction (stage 1, registered):
  - mode 00: one 54-bit lane = result_0, extended to 64 bits (sign-extend if signed, else zero).
  - mode 01: lanes k=0..2, 20 bits = {result_SIMD_carry[4k+3:4k+2], result_0[18k+17:18k]}, extended to 21 bits.
  - mode 10: lanes j=0..5, 10 bits = {result_SIMD_carry[2j+1:2j], result_0[9j+7:9j]}.
- Accumulation (stage 2): per lane, acc = first ? lane : acc + lane, modulo lane width (wrap, no saturation). No carry crosses lane boundaries.
- acc_out packing: mode 00 [63:0]; mode 01 lane k at [21k+20:21k], bit 63 = 0; mode 10 lane j at [10j+9:10j], [63:60] = 0.
- Packet FSM, states IDLE (no open packet) and ACC (packet open):
  - IDLE + beat with in_first: latch mode, count = 1 → ACC (or emit immediately if in_last).
  - IDLE + beat without in_first: treated as first; err set.
  - ACC + beat with in_first: previous packet discarded, new packet started; err set.
  - ACC + beat whose mode ≠ latched mode: beat dropped (not added, not counted); err set; in_last on it still closes the packet.
  - in_last closes the packet: acc_out/out_mode/out_count load, out_valid set → IDLE.
  - in_first & in_last on the same beat: single-beat packet.
- err clears only on reset.

## Timing
- Reset values: in_ready 1, out_valid 0, acc_out 0, out_mode 00, out_count 0, err 0, FSM IDLE, pipeline valids 0.
- Latency: beat accepted at edge t with in_last → out_valid high after edge t+2.
- stall = out_valid & ~out_ready; in_ready = ~stall (combinational). On stall, both stages and accumulators hold.
- Output register holds value until handshake; out_valid drops the cycle after acceptance unless a new result loads at the same edge (back-to-back results allowed; no bubble).
- Throughput: one beat per cycle when not stalled.
- reset asserted mid-packet: packet lost, no output, all state as above immediately (asynchronous).

## Test plan
- Mode 00 signed: a_sign=1; beats result_0 = 54'h3FFFFFFFFFFFFA (-6, first), then 10 (last) → acc_out = 64'd4, out_count = 2, out_mode = 00, two cycles after the last beat.
- Mode 01 unsigned: one beat with first&last, carry = 0, result_0 lanes 18'd5, 18'd7, 18'd9 → acc_out lanes 5, 7, 9 at bits 0, 21, 42; count 1.
- Mode 10 wrap: lane0 = 10'h3FF and then 10'h002 (unsigned), other lanes 0 → lane0 = 10'h001; lanes 1-5 = 0.
- Backpressure: out_ready = 0 with a result pending, in_valid held 5 cycles → in_ready = 0, acc_out stable; out_ready = 1 → next packet completes intact.
- Mode mismatch: packet in mode 00, mid beat mode 01 value 100 → beat dropped, err = 1, out_count excludes it.
- Reset mid-packet after 3 beats, then new 1-beat packet of 7 → acc_out = 7, count 1, err 0.
